// File: rtl/seg_display_scan.sv
// Time-multiplexed seven-segment driver: one digit active at a time, snapshot per frame,
// optional leading-zero blanking, registered active-low segment/anode/dp outputs.
module seg_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_BITS    = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_BITS-1:0] PRESC_MAX = DIV_BITS'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shd_dig_q, shd_dig_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_done_q, frame_done_d;

  logic                  tick, wrap;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic [3:0]            cur_dig;
  logic                  cur_dp, cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick = enable && (presc_q == PRESC_MAX);
    wrap = tick && (idx_q == IDX_MAX);

    presc_d = presc_q;
    if (tick)        presc_d = '0;
    else if (enable) presc_d = presc_q + DIV_BITS'(1);

    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    // While dark the shadow tracks the inputs so the first enabled frame is current.
    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    if (!enable || wrap) begin
      shd_dig_d = digits_in;
      shd_dp_d  = dp_in;
    end

    frame_done_d = wrap;
  end

  // Blanking runs from the top digit down and stops at the first non-zero digit or set dp.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (shd_dig_q[4*k +: 4] == 4'h0) && !shd_dp_q[k];
      blank_vec[k] = blank_lz && (k != 0) && zero_run;
    end
  end

  always_comb begin
    cur_dig   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_dig   = shd_dig_q[4*k +: 4];
        cur_dp    = shd_dp_q[k];
        cur_blank = blank_vec[k];
      end
    end

    an_n_d  = '1;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (enable && !cur_blank) begin
      an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d = seg_decode(cur_dig);
      dp_n_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shd_dig_q    <= '0;
      shd_dp_q     <= '0;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shd_dig_q    <= shd_dig_d;
      shd_dp_q     <= shd_dp_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: expected lit digits are queued by the stimulus and
// popped by a monitor each time a new digit lights up.
module tb_seg_display_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  seg_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DIV_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n),
    .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int d, input logic [6:0] seg, input logic dpn);
    ev_t e;
    e.an  = ~(4'b0001 << d);
    e.seg = seg;
    e.dp  = dpn;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse within 100 cycles");
    end
    #1;
  endtask

  task automatic wait_an(input logic [3:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an_n !== v && n < 100);
    if (an_n !== v) begin
      checks++;
      errors++;
      $display("FAIL an_n_timeout: got %b expected %b", an_n, v);
    end
    #1;
  endtask

  // Monitor: every new lit anode value pops one expectation; also checks hold
  // length of each digit, darkness of unlit slots and frame period.
  logic [3:0] prev_an  = 4'hF;
  bit         prev_en  = 1'b0;
  bit         hold_ok  = 1'b0;
  bit         fd_seen  = 1'b0;
  int         hold_cnt = 0;
  int         fd_cnt   = 0;

  always @(negedge clk) begin : mon
    ev_t got;
    ev_t e;
    fd_cnt++;
    if (!rst_n || !enable) begin
      hold_ok = 1'b0;
      fd_seen = 1'b0;
    end
    if (frame_done) begin
      if (fd_seen) chk("frame_period", fd_cnt, 16);
      fd_seen = 1'b1;
      fd_cnt  = 0;
    end
    if (an_n !== prev_an) begin
      if (prev_an != 4'hF && hold_ok) chk("digit_hold", hold_cnt, RD);
      if (an_n != 4'hF) begin
        got = {an_n, seg_n, dp_n};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_digit: got an_n=%b seg_n=%b dp_n=%b, none expected",
                   an_n, seg_n, dp_n);
        end else begin
          e = exp_q.pop_front();
          chk("digit", got, e);
        end
        hold_cnt = 1;
        hold_ok  = prev_en && enable && rst_n;
      end else begin
        chk("dark_slot", {seg_n, dp_n}, 8'hFF);
      end
    end else begin
      hold_cnt++;
    end
    prev_an = an_n;
    prev_en = enable;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    blank_lz  = 1'b0;
    @(negedge clk);
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    #1 rst_n = 1'b1;
    digits_in = 16'h1234;

    // Frame 1234, loaded through the disabled shadow path
    repeat (3) @(negedge clk);
    chk("idle_dark", an_n, 4'hF);
    #1;
    push_ev(0, 7'b0011001, 1'b1);
    push_ev(1, 7'b0110000, 1'b1);
    push_ev(2, 7'b0100100, 1'b1);
    push_ev(3, 7'b1111001, 1'b1);
    enable = 1'b1;

    // Frame 0000, then 5678 applied mid-frame only after the wrap
    digits_in = 16'h0000;
    for (int d = 0; d < 4; d++) push_ev(d, 7'b1000000, 1'b1);
    wait_pulse();
    wait_an(4'b1101);
    digits_in = 16'h5678;
    push_ev(0, 7'b0000000, 1'b1);
    push_ev(1, 7'b1111000, 1'b1);
    push_ev(2, 7'b0000010, 1'b1);
    push_ev(3, 7'b0010010, 1'b1);
    wait_pulse();

    // Leading-zero blanking
    blank_lz  = 1'b1;
    digits_in = 16'h0070;
    push_ev(0, 7'b1000000, 1'b1);
    push_ev(1, 7'b1111000, 1'b1);
    wait_pulse();
    dp_in = 4'b0100;
    push_ev(0, 7'b1000000, 1'b1);
    push_ev(1, 7'b1111000, 1'b1);
    push_ev(2, 7'b1000000, 1'b0);
    wait_pulse();
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    push_ev(0, 7'b1000000, 1'b1);
    wait_pulse();

    // Hex letters
    digits_in = 16'hABCD;
    push_ev(0, 7'b0100001, 1'b1);
    push_ev(1, 7'b1000110, 1'b1);
    push_ev(2, 7'b0000011, 1'b1);
    push_ev(3, 7'b0001000, 1'b1);
    wait_pulse();

    // Enable dropped at digit 2, resumed with a reloaded snapshot
    digits_in = 16'h1234;
    push_ev(0, 7'b0011001, 1'b1);
    push_ev(1, 7'b0110000, 1'b1);
    push_ev(2, 7'b0100100, 1'b1);
    wait_pulse();
    wait_an(4'b1011);
    enable    = 1'b0;
    digits_in = 16'h9876;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_an_n", an_n, 4'hF);
      chk("dis_frame_done", frame_done, 1'b0);
    end
    chk("dis_seg_n", seg_n, 7'h7F);
    #1 enable = 1'b1;
    push_ev(2, 7'b0000000, 1'b1);
    push_ev(3, 7'b0010000, 1'b1);
    push_ev(0, 7'b0000010, 1'b1);
    push_ev(1, 7'b1111000, 1'b1);
    push_ev(2, 7'b0000000, 1'b1);
    push_ev(3, 7'b0010000, 1'b1);
    wait_pulse();
    wait_pulse();

    // Asynchronous reset while frame_done is high
    rst_n = 1'b0;
    #1;
    chk("arst_an_n", an_n, 4'hF);
    chk("arst_seg_n", seg_n, 7'h7F);
    chk("arst_dp_n", dp_n, 1'b1);
    chk("arst_frame_done", frame_done, 1'b0);
    digits_in = 16'h0042;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    push_ev(0, 7'b1000000, 1'b1);
    push_ev(0, 7'b0100100, 1'b1);
    push_ev(1, 7'b0011001, 1'b1);
    wait_pulse();
    wait_pulse();
    enable = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
